// File: rtl/shifter_pkg.sv
// Shared types and constants for the multi-cycle right shifter.
package shifter_pkg;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 6;

   // Encoding 2'd3 is unused; the FSM treats it as IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Any amount of 32 or more shifts every bit out, so it is clamped to 32.
   function automatic logic [SHAMT_W-1:0] sat_amount(input logic [31:0] sel);
      return (|sel[31:5]) ? SHAMT_W'(32) : {1'b0, sel[4:0]};
   endfunction

endpackage

// File: rtl/shr_step.sv
// One combinational step of the shifter: data >> k, with the vacated top k bits set to fill.
module shr_step
   import shifter_pkg::*;
(
   input  logic [WIDTH-1:0] data,
   input  logic [3:0]       k,
   input  logic             fill,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] ones;
   assign ones = '1;

   always_comb begin
      result = data >> k;
      if (fill) result = result | ~(ones >> k);
   end

endmodule

// File: rtl/shifter_right_32_bits_seq.sv
// Multi-cycle 32-bit right shifter with valid/ready handshakes, up to STEP bits per clock.
// Define SHR_ARITH_EN to honour the Arith port; without it, fill is always 0.
//
// state | meaning
// IDLE  | waiting for an operand, In_ready=1
// SHIFT | consuming the shift amount, STEP bits at most per cycle
// DONE  | result on Out, Out_valid=1, waiting for Out_ready
module shifter_right_32_bits_seq
   import shifter_pkg::*;
#(
   parameter int STEP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [WIDTH-1:0] In,
   input  logic [31:0]      Sel,
   input  logic             Arith,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [WIDTH-1:0] Out
);

   localparam logic [SHAMT_W-1:0] STEP_W = SHAMT_W'(STEP);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]           k;
   logic                 fill;
   logic                 accept;
   logic [WIDTH-1:0]     shifted;

   assign accept = In_valid && (state_q == IDLE);

`ifdef SHR_ARITH_EN
   // Sign is captured once at accept; every step fills with it, not the running MSB.
   logic fill_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         fill_q <= 1'b0;
      else if (accept) fill_q <= Arith & In[WIDTH-1];
   end
   assign fill = fill_q;
`else
   logic unused_arith;
   assign unused_arith = Arith;
   assign fill         = 1'b0;
`endif

   assign k = (cnt_q < STEP_W) ? cnt_q[3:0] : 4'(STEP);

   shr_step u_step (
      .data   (data_q),
      .k      (k),
      .fill   (fill),
      .result (shifted)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      out_d     = out_q;
      cnt_d     = cnt_q;
      In_ready  = 1'b0;
      Out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            In_ready = 1'b1;
            if (In_valid) begin
               data_d = In;
               cnt_d  = sat_amount(Sel);
               if (cnt_d == '0) begin
                  state_d = DONE;
                  out_d   = In;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            data_d = shifted;
            cnt_d  = cnt_q - {2'b00, k};
            if (cnt_d == '0) begin
               state_d = DONE;
               out_d   = shifted;
            end
         end
         DONE: begin
            Out_valid = 1'b1;
            if (Out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Out is a separate register so it keeps the last result after the handshake.
   assign Out = out_q;

endmodule

// File: tb/tb_shifter_right_32_bits_seq.sv
// Scoreboard bench for shifter_right_32_bits_seq: directed vectors, decoupled result monitor.
module tb_shifter_right_32_bits_seq;

   localparam int STEP = 1;
`ifdef SHR_ARITH_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        In_valid = 1'b0;
   logic        Arith = 1'b0;
   logic        Out_ready = 1'b1;
   logic [31:0] In = '0;
   logic [31:0] Sel = '0;
   logic        In_ready;
   logic        Out_valid;
   logic [31:0] Out;

   shifter_right_32_bits_seq #(.STEP(STEP)) dut (
      .clk       (clk),
      .rst       (rst),
      .In_valid  (In_valid),
      .In_ready  (In_ready),
      .In        (In),
      .Sel       (Sel),
      .Arith     (Arith),
      .Out_valid (Out_valid),
      .Out_ready (Out_ready),
      .Out       (Out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] exp;
      int          acc;
      int          lat;
   } item_t;

   item_t sb[$];
   item_t cur;
   int    cyc    = 0;
   int    n_pass = 0;
   int    n_chk  = 0;
   logic  prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
   endtask

   // Monitor: a rising Out_valid pops the next expected result; while held, Out must not move.
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (Out_valid && !prev_v) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_result: got 0x%08h with no operation outstanding", Out);
            end else begin
               cur = sb.pop_front();
               chk("result", Out, cur.exp);
               chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            end
         end else if (Out_valid) begin
            chk("hold", Out, cur.exp);
         end
         prev_v = Out_valid;
      end
   end

   task automatic op(input logic [31:0] din, input logic [31:0] sel, input logic a,
                     input logic [31:0] exp, input bit push);
      int t = 0;
      int m;
      @(negedge clk);
      while (!In_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!In_ready) begin
         n_chk++;
         $display("FAIL accept_timeout: In_ready got 0 want 1");
         return;
      end
      In       = din;
      Sel      = sel;
      Arith    = a;
      In_valid = 1'b1;
      @(posedge clk);
      #1;
      In_valid = 1'b0;
      In       = 32'hDEAD_BEEF;
      Sel      = 32'h0000_0005;
      Arith    = ~a;
      m = (sel >= 32) ? 32 : int'(sel);
      if (push) sb.push_back('{exp: exp, acc: cyc, lat: (m + STEP - 1) / STEP});
   endtask

   task automatic wait_done();
      int t = 0;
      while ((sb.size() != 0 || Out_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0 || Out_valid) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      #1;
      chk("rst_in_ready", {31'd0, In_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, Out_valid}, 32'd0);
      chk("rst_out", Out, 32'h0);
      #11 rst = 1'b0;

      op(32'h8000_0000, 32'd1,    1'b0, 32'h4000_0000, 1'b1);
      op(32'h8000_0000, 32'd0,    1'b0, 32'h8000_0000, 1'b1);
      op(32'hFFFF_FFFF, 32'd3,    1'b0, 32'h1FFF_FFFF, 1'b1);
      op(32'h8000_0000, 32'd31,   1'b1, AR ? 32'hFFFF_FFFF : 32'h0000_0001, 1'b1);
      op(32'h8000_0000, 32'h40,   1'b1, AR ? 32'hFFFF_FFFF : 32'h0000_0000, 1'b1);
      op(32'h8000_0000, 32'h40,   1'b0, 32'h0000_0000, 1'b1);
      op(32'h1234_5678, 32'd4,    1'b1, 32'h0123_4567, 1'b1);
      op(32'h8765_4321, 32'd8,    1'b1, AR ? 32'hFF87_6543 : 32'h0087_6543, 1'b1);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1);
      op(32'h8000_0001, 32'd32,   1'b1, AR ? 32'hFFFF_FFFF : 32'h0000_0000, 1'b1);
      op(32'h0F0F_0000, 32'd16,   1'b0, 32'h0000_0F0F, 1'b1);
      wait_done();

      // Backpressure: result must hold and new requests must be ignored.
      Out_ready = 1'b0;
      op(32'hA5A5_A5A5, 32'd4, 1'b0, 32'h0A5A_5A5A, 1'b1);
      t = 0;
      while (!Out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("bp_reached_done", {31'd0, Out_valid}, 32'd1);
      repeat (5) begin
         @(negedge clk);
         In_valid = 1'b1;
         In       = 32'h0000_0001;
         Sel      = 32'd0;
         chk("bp_in_ready", {31'd0, In_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, Out_valid}, 32'd1);
      end
      @(negedge clk);
      In_valid  = 1'b0;
      Out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out_valid", {31'd0, Out_valid}, 32'd0);
      chk("release_in_ready", {31'd0, In_ready}, 32'd1);
      chk("release_out_kept", Out, 32'h0A5A_5A5A);
      repeat (3) @(negedge clk);
      chk("release_still_idle", {31'd0, In_ready}, 32'd1);

      // Reset in the middle of a shift.
      op(32'hF000_0000, 32'd20, 1'b0, 32'h0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("shift_in_ready", {31'd0, In_ready}, 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_out", Out, 32'h0);
      chk("midrst_out_valid", {31'd0, Out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, In_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      op(32'hF000_0000, 32'd20, 1'b0, 32'h0000_0F00, 1'b1);
      op(32'hF000_0000, 32'd20, 1'b1, AR ? 32'hFFFF_FF00 : 32'h0000_0F00, 1'b1);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
